// File: rtl/multdiv_seq_if.sv
// Operand/result bundle between the execute stage and multdiv_seq.
// The execute stage drives the master side; the unit itself is the slave.
interface multdiv_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_operandA;
  logic [DATA_WIDTH-1:0] data_operandB;
  logic                  ctrl_MULT;
  logic                  ctrl_DIV;
  logic [DATA_WIDTH-1:0] data_result;
  logic                  data_exception;
  logic                  data_resultRDY;
  logic                  busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_seq.sv
// Multi-cycle signed multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULTDIV_BOOTH_RADIX4_EN for a radix-4 Booth multiply at half the iterations.
module multdiv_seq #(
  parameter int DATA_WIDTH = 32,
`ifdef MULTDIV_BOOTH_RADIX4_EN
  parameter int ITER_MULT  = DATA_WIDTH / 2,
`else
  parameter int ITER_MULT  = DATA_WIDTH,
`endif
  parameter int ITER_DIV   = DATA_WIDTH
) (
  input  logic         clock,
  input  logic         reset_n,
  multdiv_seq_if.slave bus
);
  localparam int W = DATA_WIDTH;
`ifdef MULTDIV_BOOTH_RADIX4_EN
  localparam int ACC_W = 2 * W + 3;  // {hi[W+1:0], multiplier[W-1:0], booth guard bit}
`else
  localparam int ACC_W = 2 * W;
`endif
  localparam int            CNT_W   = $clog2(ITER_DIV + 1);
  localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN_MULT, S_RUN_DIV, S_FINISH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             div_zero_q, div_zero_d;
  logic             div_ovf_q, div_ovf_d;
  logic [W-1:0]     opa_q, opa_d;     // multiplicand, or divisor magnitude
  logic [W-1:0]     rem_q, rem_d;
  logic [ACC_W-1:0] acc_q, acc_d;     // product accumulator, or dividend/quotient in [W-1:0]
  logic [W-1:0]     result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic             start;
  logic [ACC_W-1:0] mult_next;
  logic [2*W-1:0]   product;
  logic [W:0]       div_shift;
  logic             div_take;
  logic [W-1:0]     quotient;
  logic [W-1:0]     fin_result;
  logic             fin_exc;

  // INT_MIN maps onto the unsigned value 2^(W-1), which still fits in W bits.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;

`ifdef MULTDIV_BOOTH_RADIX4_EN
  logic signed [W+1:0] a_ext, booth_add, booth_hi;

  always_comb begin
    a_ext = {{2{opa_q[W-1]}}, opa_q};
    unique case (acc_q[2:0])
      3'b001, 3'b010: booth_add = a_ext;
      3'b011:         booth_add = a_ext <<< 1;
      3'b100:         booth_add = -(a_ext <<< 1);
      3'b101, 3'b110: booth_add = -a_ext;
      default:        booth_add = '0;
    endcase
    booth_hi  = $signed(acc_q[ACC_W-1:W+1]) + booth_add;
    mult_next = $signed({booth_hi, acc_q[W:0]}) >>> 2;
    product   = acc_q[2*W:1];
  end
`else
  logic [W:0] r2_sum;

  always_comb begin
    r2_sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mult_next = {r2_sum, acc_q[W-1:1]};
    product   = neg_q ? -acc_q : acc_q;
  end
`endif

  always_comb begin
    div_shift = {rem_q, acc_q[W-1]};
    div_take  = (div_shift >= {1'b0, opa_q});
  end

  // The restoring loop yields 2^(W-1) for INT_MIN/-1, which is exactly the required result.
  always_comb begin
    quotient   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    fin_result = product[W-1:0];
    fin_exc    = !((&product[2*W-1:W-1]) || !(|product[2*W-1:W-1]));
    if (is_div_q) begin
      fin_result = div_zero_q ? '0 : quotient;
      fin_exc    = div_zero_q | div_ovf_q;
    end
  end

  always_comb begin
    // NOTE: every _d takes its _q value first so no branch leaves a signal unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    div_zero_d = div_zero_q;
    div_ovf_d  = div_ovf_q;
    opa_d      = opa_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    result_d   = result_q;
    exc_d      = exc_q;
    rdy_d      = 1'b0;

    if (start) begin
      // A start in any state, FINISH included, abandons the op in flight.
      state_d    = bus.ctrl_MULT ? S_RUN_MULT : S_RUN_DIV;
      is_div_d   = ~bus.ctrl_MULT;
      cnt_d      = '0;
      neg_d      = bus.data_operandA[W-1] ^ bus.data_operandB[W-1];
      div_zero_d = (bus.data_operandB == '0);
      div_ovf_d  = (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
      rem_d      = '0;
      if (bus.ctrl_MULT) begin
`ifdef MULTDIV_BOOTH_RADIX4_EN
        opa_d = bus.data_operandA;
        acc_d = {{(W+2){1'b0}}, bus.data_operandB, 1'b0};
`else
        opa_d = magnitude(bus.data_operandA);
        acc_d = {{W{1'b0}}, magnitude(bus.data_operandB)};
`endif
      end else begin
        opa_d = magnitude(bus.data_operandB);
        acc_d = {{(ACC_W-W){1'b0}}, magnitude(bus.data_operandA)};
      end
    end else begin
      unique case (state_q)
        S_RUN_MULT: begin
          acc_d = mult_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER_MULT - 1)) state_d = S_FINISH;
        end
        S_RUN_DIV: begin
          acc_d = {acc_q[ACC_W-1:W], acc_q[W-2:0], div_take};
          rem_d = div_take ? W'(div_shift - {1'b0, opa_q}) : div_shift[W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER_DIV - 1)) state_d = S_FINISH;
        end
        S_FINISH: begin
          state_d  = S_IDLE;
          result_d = fin_result;
          exc_d    = fin_exc;
          rdy_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath registers are
  // few and small, so all of them are cleared by the async reset rather than left undefined.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      opa_q      <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
      opa_q      <= opa_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
      rdy_q      <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed corner cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_multdiv_seq;
`ifdef MULTDIV_BOOTH_RADIX4_EN
  localparam int MULT_LAT = 17;
`else
  localparam int MULT_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clock = 1'b0;
  logic reset_n;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] held_r;
  logic held_e;

  multdiv_seq_if #(.DATA_WIDTH(32)) mif ();
  multdiv_seq dut (.clock(clock), .reset_n(reset_n), .bus(mif));

  always #5 clock = ~clock;

  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int q;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p > 64'sh7FFF_FFFF) || (p < -64'sh8000_0000);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 65535));
      5: return 32'(-int'($urandom_range(0, 65535)));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge right after the start edge.
  task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    mif.ctrl_MULT = m;
    mif.ctrl_DIV = d;
    mif.data_operandA = a;
    mif.data_operandB = b;
    @(negedge clock);
    mif.ctrl_MULT = 1'b0;
    mif.ctrl_DIV = 1'b0;
  endtask

  // Scrambles the operand ports every cycle while waiting; lat = -1 on timeout.
  task automatic wait_rdy(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      mif.data_operandA = $urandom;
      mif.data_operandB = $urandom;
      @(negedge clock);
      if (mif.data_resultRDY === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e, input string name);
    int lat;
    int exp_lat;
    exp_lat = m ? MULT_LAT : DIV_LAT;
    pulse(m, d, a, b);
    n_checks++;
    if (mif.busy !== 1'b1 || mif.data_result !== held_r || mif.data_exception !== held_e) begin
      n_errors++;
      $display("FAIL %s start: busy=%b result=%h exc=%b, expected busy=1 result=%h exc=%b",
               name, mif.busy, mif.data_result, mif.data_exception, held_r, held_e);
    end
    wait_rdy(exp_lat + 8, lat);
    n_checks++;
    if (lat != exp_lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (mif.data_result !== exp_r) begin
      n_errors++;
      $display("FAIL %s result: got %h, expected %h (a=%h b=%h)", name, mif.data_result, exp_r, a, b);
    end
    n_checks++;
    if (mif.data_exception !== exp_e) begin
      n_errors++;
      $display("FAIL %s exception: got %b, expected %b (a=%h b=%h)", name, mif.data_exception, exp_e, a, b);
    end
    @(negedge clock);
    n_checks++;
    if (mif.data_resultRDY !== 1'b0 || mif.busy !== 1'b0 || mif.data_result !== exp_r ||
        mif.data_exception !== exp_e) begin
      n_errors++;
      $display("FAIL %s after strobe: rdy=%b busy=%b result=%h exc=%b, expected rdy=0 busy=0 result=%h exc=%b",
               name, mif.data_resultRDY, mif.busy, mif.data_result, mif.data_exception, exp_r, exp_e);
    end
    held_r = exp_r;
    held_e = exp_e;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    mif.ctrl_MULT = 1'b0;
    mif.ctrl_DIV = 1'b0;
    mif.data_operandA = '0;
    mif.data_operandB = '0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (mif.data_result !== 32'd0 || mif.data_exception !== 1'b0 || mif.data_resultRDY !== 1'b0 ||
        mif.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset asserted: result=%h exc=%b rdy=%b busy=%b, expected all 0",
               mif.data_result, mif.data_exception, mif.data_resultRDY, mif.busy);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (mif.data_result !== 32'd0 || mif.data_exception !== 1'b0 || mif.data_resultRDY !== 1'b0 ||
        mif.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset released: result=%h exc=%b rdy=%b busy=%b, expected all 0",
               mif.data_result, mif.data_exception, mif.data_resultRDY, mif.busy);
    end
    held_r = 32'd0;
    held_e = 1'b0;
  endtask

  task automatic test_mult();
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, "mult_7x-6");
    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mult_ovf");
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "mult_intmin_x1");
  endtask

  task automatic test_div();
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_-7by2");
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, "div_by_zero");
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_intmin_by_-1");
  endtask

  task automatic test_simultaneous();
    run_op(1'b1, 1'b1, 32'd9, 32'd3, 32'd27, 1'b0, "both_starts");
  endtask

  task automatic test_restart();
    int n_rdy;
    int first;
    bit moved;
    int lat;
    logic [31:0] r_at;
    logic e_at;
    // Restart mid-multiply with a divide.
    pulse(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (10) @(negedge clock);
    pulse(1'b0, 1'b1, 32'd100, 32'd7);
    n_rdy = 0;
    first = -1;
    moved = 1'b0;
    r_at = '0;
    e_at = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (mif.data_resultRDY === 1'b1) begin
        n_rdy++;
        if (first < 0) begin
          first = i;
          r_at = mif.data_result;
          e_at = mif.data_exception;
        end
      end else if (first < 0 && mif.data_result !== held_r) begin
        moved = 1'b1;
      end
    end
    n_checks++;
    if (n_rdy != 1 || first != DIV_LAT) begin
      n_errors++;
      $display("FAIL restart strobes: got %0d strobes first at %0d, expected 1 at %0d", n_rdy, first, DIV_LAT);
    end
    n_checks++;
    if (r_at !== 32'd14 || e_at !== 1'b0) begin
      n_errors++;
      $display("FAIL restart result: got %h exc=%b, expected 0000000e exc=0", r_at, e_at);
    end
    n_checks++;
    if (moved) begin
      n_errors++;
      $display("FAIL restart hold: result changed before strobe, expected %h held", held_r);
    end
    held_r = 32'd14;
    held_e = 1'b0;
    // Restart pulse landing exactly in the FINISH cycle of a divide.
    pulse(1'b0, 1'b1, 32'd1000, 32'd10);
    repeat (DIV_LAT - 1) @(negedge clock);
    n_checks++;
    if (mif.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL finish_restart busy: got %b, expected 1", mif.busy);
    end
    pulse(1'b0, 1'b1, 32'd200, 32'hFFFF_FFF7);
    n_checks++;
    if (mif.data_resultRDY !== 1'b0 || mif.data_result !== held_r) begin
      n_errors++;
      $display("FAIL finish_restart suppress: rdy=%b result=%h, expected rdy=0 result=%h",
               mif.data_resultRDY, mif.data_result, held_r);
    end
    wait_rdy(DIV_LAT + 8, lat);
    n_checks++;
    if (lat != DIV_LAT || mif.data_result !== 32'hFFFF_FFEA || mif.data_exception !== 1'b0) begin
      n_errors++;
      $display("FAIL finish_restart result: lat=%0d result=%h exc=%b, expected lat=%0d result=ffffffea exc=0",
               lat, mif.data_result, mif.data_exception, DIV_LAT);
    end
    @(negedge clock);
    held_r = 32'hFFFF_FFEA;
    held_e = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    pulse(1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
    wait_rdy(MULT_LAT + 8, lat);
    n_checks++;
    if (lat != MULT_LAT || mif.data_result !== 32'd15 || mif.data_exception !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b first: lat=%0d result=%h exc=%b, expected lat=%0d result=0000000f exc=0",
               lat, mif.data_result, mif.data_exception, MULT_LAT);
    end
    pulse(1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    n_checks++;
    if (mif.data_resultRDY !== 1'b0 || mif.busy !== 1'b1 || mif.data_result !== 32'd15) begin
      n_errors++;
      $display("FAIL b2b overlap: rdy=%b busy=%b result=%h, expected rdy=0 busy=1 result=0000000f",
               mif.data_resultRDY, mif.busy, mif.data_result);
    end
    wait_rdy(DIV_LAT + 8, lat);
    n_checks++;
    if (lat != DIV_LAT || mif.data_result !== 32'h8000_0001 || mif.data_exception !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b second: lat=%0d result=%h exc=%b, expected lat=%0d result=80000001 exc=0",
               lat, mif.data_result, mif.data_exception, DIV_LAT);
    end
    @(negedge clock);
    held_r = 32'h8000_0001;
    held_e = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic e;
    bit is_div;
    for (int i = 0; i < 30; i++) begin
      is_div = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      model(is_div, a, b, r, e);
      run_op(!is_div, is_div, a, b, r, e, is_div ? "rand_div" : "rand_mult");
    end
  endtask

  task automatic test_reset_midop();
    int n_rdy;
    pulse(1'b1, 1'b0, 32'h0000_1234, 32'h0000_5678);
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (mif.data_result !== 32'd0 || mif.data_exception !== 1'b0 || mif.data_resultRDY !== 1'b0 ||
        mif.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midop reset: result=%h exc=%b rdy=%b busy=%b, expected all 0",
               mif.data_result, mif.data_exception, mif.data_resultRDY, mif.busy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    n_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mif.data_resultRDY !== 1'b0) n_rdy++;
    end
    n_checks++;
    if (n_rdy != 0 || mif.busy !== 1'b0 || mif.data_result !== 32'd0) begin
      n_errors++;
      $display("FAIL midop abort: strobes=%0d busy=%b result=%h, expected 0 strobes busy=0 result=0",
               n_rdy, mif.busy, mif.data_result);
    end
    held_r = 32'd0;
    held_e = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_simultaneous();
    test_restart();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog timeout");
  end
endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Multi-cycle signed 32-bit multiply/divide unit. Sits beside the single-cycle ALU in the execute stage.
- Handles the arithmetic ops the ALU cannot finish in one cycle: mul and div.
- Start is a one-cycle pulse. Result returns after a fixed latency with a one-cycle ready strobe; the pipeline stalls until the strobe arrives.
- Produces a result plus an exception flag. The exception flag plays the same role as the ALU overflow flag for writeback and rstatus logic.

Parameters:
- DATA_WIDTH, 32: operand and result width. Only 32 is verified.
- ITER_MULT, 32: multiply iteration count. Must equal DATA_WIDTH; becomes DATA_WIDTH/2 under the optional feature.
- ITER_DIV, 32: divide iteration count. Must equal DATA_WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- data_operandA  in  32  multiplicand / dividend, two's complement. Sampled only on a start edge.
- data_operandB  in  32  multiplier / divisor, two's complement. Sampled only on a start edge.
- ctrl_MULT  in  1  one-cycle start pulse for A*B.
- ctrl_DIV  in  1  one-cycle start pulse for A/B.
- data_result  out  32  low 32 bits of the product, or the quotient.
- data_exception  out  1  product overflow, divide-by-zero, or INT_MIN/-1.
- data_resultRDY  out  1  one-cycle strobe; result and exception are valid.
- busy  out  1  high while an operation is in flight (RUN_MULT, RUN_DIV or FINISH).

Behaviour:
- Reset: reset_n low asynchronously forces the following. All outputs are 0 while reset_n is low and on the first edge after release.
  - state = IDLE
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0
  - counter = 0 and internal registers cleared
- Reset during an operation aborts it; no RDY is ever produced for the aborted op.
- States:
  - IDLE -> RUN_MULT on ctrl_MULT. IDLE -> RUN_DIV on ctrl_DIV.
  - RUN_MULT -> FINISH when count == ITER_MULT-1. RUN_DIV -> FINISH when count == ITER_DIV-1.
  - FINISH -> IDLE unconditionally; this edge registers result/exception and sets RDY.
- Start edge: latch A and B, clear counter, set busy.
  - Both ctrl_MULT and ctrl_DIV high on the same edge: MULT wins.
- Start while busy (any state, including FINISH): the current op is abandoned and the new op restarts from its start edge.
  - The abandoned op never raises RDY.
  - A start pulse coincident with FINISH suppresses that FINISH's RDY.
- Latency: RDY is high in the cycle after the 33rd rising edge following the start edge (ITER+1). RDY is high for exactly one cycle.
- data_result and data_exception are updated only on the FINISH edge. They hold until the next FINISH or reset; they do not change when a new op starts.
- Multiply:
  - Radix-2 shift-add on operand magnitudes, 64-bit accumulator, one bit per cycle. Sign is applied on FINISH.
  - Result = product[31:0].
  - Exception = 1 iff the 64-bit signed product is outside [-2^31, 2^31-1], i.e. product[63:31] is not all-0 and not all-1.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle. Quotient truncates toward zero; quotient sign = signA ^ signB; remainder is discarded.
  - B == 0: result = 0, exception = 1. The full latency is still taken.
  - A == 0x80000000 and B == 0xFFFFFFFF: result = 0x80000000, exception = 1.
- Magnitude of 0x80000000 is handled as 33-bit unsigned 2^31; no internal overflow.
- Operand ports changing mid-operation have no effect.

Optional Feature:
- Macro: MULTDIV_BOOTH_RADIX4_EN.
- Defined: multiply uses radix-4 Booth recoding directly on signed operands, two bits per cycle.
  - ITER_MULT = 16, so mult RDY comes 17 edges after start.
  - Results and exceptions are identical to radix-2.
- Undefined: radix-2 multiply, 33-edge latency.
- Divide latency is unchanged in both cases.

Test Plan:
- Reset: reset_n=0 mid-MULT -> all outputs 0 immediately; no RDY for the following 40 cycles.
- MULT A=7, B=-6 (0xFFFFFFFA) -> RDY 33 edges later (17 with Booth): result 0xFFFFFFD6, exception 0. RDY high exactly 1 cycle; result held afterward.
- MULT A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. MULT 0x80000000 * 1 -> 0x80000000, exception 0.
- DIV -7/2 -> 0xFFFFFFFD, exception 0. DIV 5/0 -> 0, exception 1 at 33 edges. DIV 0x80000000/-1 -> 0x80000000, exception 1.
- Restart: MULT 3*4 started, then DIV 100/7 pulsed 10 cycles later -> exactly one RDY, 33 edges after the DIV pulse, result 14, exception 0.
- Simultaneous ctrl_MULT=ctrl_DIV=1 with A=9, B=3 -> result 27 (multiply), exception 0.
